// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one multi-cycle float unit between two requesters.
// Define FLOAT_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (abort after TIMEOUT cycles).
module float_copro_arbiter #(
   parameter int N_EXP   = 8,
   parameter int N_MANT  = 23,
   parameter int W       = 1 + N_EXP + N_MANT,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic [1:0]     req_valid_i,
   output logic [1:0]     req_ready_o,
   input  logic [3:0]     req_op_i,
   input  logic [2*W-1:0] req_a_i,
   input  logic [2*W-1:0] req_b_i,
   output logic [1:0]     rsp_valid_o,
   input  logic [1:0]     rsp_ready_i,
   output logic [W-1:0]   rsp_data_o,
   output logic           rsp_err_o,
   output logic           fu_start_o,
   output logic [1:0]     fu_op_o,
   output logic [W-1:0]   fu_a_o,
   output logic [W-1:0]   fu_b_o,
   input  logic           fu_done_i,
   input  logic [W-1:0]   fu_result_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0]  OP_RSVD = 2'b11;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t         state_q, state_d;
   logic           rr_q, rr_d;
   logic           owner_q, owner_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   data_q, data_d;
   logic           err_q, err_d;

   logic           winner;
   logic           accept;
   logic           timeout_hit;
   logic [1:0]     win_op;
   logic [W-1:0]   win_a;
   logic [W-1:0]   win_b;

   // Pointer only matters on contention; a lone requester always wins.
   assign winner = (req_valid_i == 2'b11) ? rr_q : req_valid_i[1];
   assign win_op = winner ? req_op_i[3:2]      : req_op_i[1:0];
   assign win_a  = winner ? req_a_i[2*W-1:W]   : req_a_i[W-1:0];
   assign win_b  = winner ? req_b_i[2*W-1:W]   : req_b_i[W-1:0];

   // nrst gating keeps req_ready low while reset is asserted.
   assign accept = nrst && (state_q == S_IDLE) && (req_valid_i != 2'b00);

`ifdef FLOAT_ARB_TIMEOUT_EN
   logic [15:0] wd_q, wd_d;

   always_comb begin
      wd_d = wd_q;
      if (state_q == S_ISSUE)
         wd_d = '0;
      else if (state_q == S_WAIT)
         wd_d = wd_q + 16'd1;
   end

   assign timeout_hit = (state_q == S_WAIT) && (wd_q == TO_LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         wd_q <= '0;
      else
         wd_q <= wd_d;
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = ^TO_LAST;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               owner_d = winner;
               rr_d    = ~winner;
               if (win_op == OP_RSVD) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  op_d    = win_op;
                  a_d     = win_a;
                  b_d     = win_b;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // A completion in the expiry cycle still delivers the real result.
            if (fu_done_i) begin
               data_d  = fu_result_i;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i[owner_q])
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid_o = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data_o  = data_q;
   assign rsp_err_o   = err_q;
   assign fu_start_o  = (state_q == S_ISSUE);
   assign fu_op_o     = op_q;
   assign fu_a_o      = a_q;
   assign fu_b_o      = b_q;

endmodule
